// File: rtl/redirect_ctrl.sv
// redirect_ctrl -- execute-stage control-flow redirect sequencer.
//
// Compares the resolved next PC of each EX instruction against the PC that
// fetch predicted. On a mismatch, ecall or mret it flushes the younger stages
// and holds a redirect request to the IFU until the IFU accepts it. Every
// resolved control-flow instruction also produces a one-cycle predictor update.
//
// Ports:
//   clock, reset          core clock, synchronous active-high reset
//   ex_valid_i            EX holds a valid instruction
//   ex_pc_i               PC of the EX instruction
//   ex_pred_pc_i          next PC predicted by fetch
//   ex_npc_i              resolved next PC from the branch unit
//   ex_is_ctrl_i          branch / jal / jalr / ecall / mret
//   ex_is_trap_i          ecall / mret (always redirects)
//   flush_o               kill IF/ID and ID/EX (combinational from EX inputs)
//   redir_valid_o/pc_o    registered redirect request and target
//   redir_ready_i         IFU accepts the redirect
//   bp_upd_*_o            registered one-cycle predictor update
//
// Optional feature (macro YSYX_23060251_REDIRECT_PERF_EN):
//   perf_ctrl_cnt_o       resolved control-flow instructions
//   perf_mispred_cnt_o    redirects entered from IDLE (traps included)

module redirect_ctrl #(
  parameter int PC_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [PC_W-1:0] ex_pred_pc_i,
  input  logic [PC_W-1:0] ex_npc_i,
  input  logic            ex_is_ctrl_i,
  input  logic            ex_is_trap_i,
  output logic            flush_o,
  output logic            redir_valid_o,
  output logic [PC_W-1:0] redir_pc_o,
  input  logic            redir_ready_i,
  output logic            bp_upd_valid_o,
  output logic [PC_W-1:0] bp_upd_pc_o,
  output logic [PC_W-1:0] bp_upd_target_o,
  output logic            bp_upd_taken_o
`ifdef YSYX_23060251_REDIRECT_PERF_EN
  ,
  output logic [31:0]     perf_ctrl_cnt_o,
  output logic [31:0]     perf_mispred_cnt_o
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

  state_t          state_r;
  state_t          state_s;
  logic            resolve_s;
  logic            need_redir_s;
  logic            enter_redir_s;
  logic            handshake_s;
  logic            upd_fire_s;
  logic            flush_s;
  logic            redir_valid_r;
  logic [PC_W-1:0] redir_pc_r;
  logic            bp_upd_valid_r;
  logic [PC_W-1:0] bp_upd_pc_r;
  logic [PC_W-1:0] bp_upd_target_r;
  logic            bp_upd_taken_r;

  // Event decode: what the EX instruction asks for in the current state.
  always_comb begin
    resolve_s     = ex_valid_i && (state_r == IDLE);
    need_redir_s  = ex_is_trap_i || (ex_npc_i != ex_pred_pc_i);
    enter_redir_s = resolve_s && need_redir_s;
    upd_fire_s    = resolve_s && ex_is_ctrl_i;
    handshake_s   = redir_valid_r && redir_ready_i;
  end

  // Next-state logic and the combinational flush.
  always_comb begin
    state_s = state_r;
    flush_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enter_redir_s) begin
          state_s = REDIR;
          flush_s = 1'b1;
        end else begin
          state_s = IDLE;
          flush_s = 1'b0;
        end
      end
      REDIR: begin
        // Wrong-path fetches keep arriving until the IFU takes the target.
        flush_s = 1'b1;
        if (handshake_s) begin
          state_s = IDLE;
        end else begin
          state_s = REDIR;
        end
      end
      default: begin
        state_s = IDLE;
        flush_s = 1'b0;
      end
    endcase
  end

  // State register and redirect request; the target is captured on entry only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      redir_valid_r <= 1'b0;
      redir_pc_r    <= '0;
    end else begin
      state_r <= state_s;
      if (enter_redir_s) begin
        redir_valid_r <= 1'b1;
        redir_pc_r    <= ex_npc_i;
      end else if (handshake_s) begin
        redir_valid_r <= 1'b0;
      end
    end
  end

  // Predictor update pulse; payload is held between pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      bp_upd_valid_r  <= 1'b0;
      bp_upd_pc_r     <= '0;
      bp_upd_target_r <= '0;
      bp_upd_taken_r  <= 1'b0;
    end else begin
      bp_upd_valid_r <= upd_fire_s;
      if (upd_fire_s) begin
        bp_upd_pc_r     <= ex_pc_i;
        bp_upd_target_r <= ex_npc_i;
        // Sequential fall-through wraps with the PC width.
        bp_upd_taken_r  <= (ex_npc_i != (ex_pc_i + PC_STEP));
      end
    end
  end

  assign flush_o         = flush_s;
  assign redir_valid_o   = redir_valid_r;
  assign redir_pc_o      = redir_pc_r;
  assign bp_upd_valid_o  = bp_upd_valid_r;
  assign bp_upd_pc_o     = bp_upd_pc_r;
  assign bp_upd_target_o = bp_upd_target_r;
  assign bp_upd_taken_o  = bp_upd_taken_r;

`ifdef YSYX_23060251_REDIRECT_PERF_EN
  logic [31:0] perf_ctrl_cnt_r;
  logic [31:0] perf_mispred_cnt_r;

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ctrl_cnt_r    <= 32'd0;
      perf_mispred_cnt_r <= 32'd0;
    end else begin
      if (upd_fire_s) begin
        perf_ctrl_cnt_r <= perf_ctrl_cnt_r + 32'd1;
      end
      if (enter_redir_s) begin
        perf_mispred_cnt_r <= perf_mispred_cnt_r + 32'd1;
      end
    end
  end

  assign perf_ctrl_cnt_o    = perf_ctrl_cnt_r;
  assign perf_mispred_cnt_o = perf_mispred_cnt_r;
`endif

`ifndef SYNTHESIS
  redirect_ctrl_chk u_chk (
    .clock    (clock),
    .reset    (reset),
    .in_redir (state_r == REDIR),
    .ex_valid (ex_valid_i)
  );
`endif

endmodule

// Simulation-only checker: ID/EX is flushed during a redirect, so a valid
// EX instruction while redirecting means the pipeline control is broken.
module redirect_ctrl_chk (
  input logic clock,
  input logic reset,
  input logic in_redir,
  input logic ex_valid
);

  a_no_ex_in_redir: assert property (@(posedge clock) disable iff (reset)
    in_redir |-> !ex_valid);

endmodule
